ir_frame_ctrl: RTL and testbench

IR_FRAME_CTRL -- requirements
Module: ir_frame_ctrl

---
 rtl/ir_pkg.sv | 37 +++
 rtl/pulse_timer.sv | 26 ++
 rtl/ir_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_ir_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types, counter width and tick windows for the NEC IR frame receiver.
package ir_pkg;

  localparam int TCOUNT_W = 8;

  typedef logic [TCOUNT_W-1:0] tcount_t;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } state_t;

  // Phase windows in ticks (1 tick = 56.25 us), limits inclusive.
  localparam tcount_t LEAD_MARK_MIN  = 8'd144;
  localparam tcount_t LEAD_MARK_MAX  = 8'd176;
  localparam tcount_t FRAME_SPACE_MIN = 8'd72;
  localparam tcount_t FRAME_SPACE_MAX = 8'd88;
  localparam tcount_t REP_SPACE_MIN  = 8'd32;
  localparam tcount_t REP_SPACE_MAX  = 8'd48;
  localparam tcount_t BIT_MARK_MIN   = 8'd7;
  localparam tcount_t BIT_MARK_MAX   = 8'd13;
  localparam tcount_t ZERO_SPACE_MIN = 8'd7;
  localparam tcount_t ZERO_SPACE_MAX = 8'd13;
  localparam tcount_t ONE_SPACE_MIN  = 8'd25;
  localparam tcount_t ONE_SPACE_MAX  = 8'd35;
  localparam tcount_t STOP_MARK_MIN  = 8'd7;
  localparam tcount_t STOP_MARK_MAX  = 8'd13;

  function automatic logic in_window(tcount_t c, tcount_t lo, tcount_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Saturating phase-length counter: clear wins over tick, holds at all-ones.
module pulse_timer
  import ir_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clear,
  input  logic                i_tick,
  output logic [TCOUNT_W-1:0] o_count,
  output logic                o_sat
);

  assign o_sat = &o_count;

  // Count ticks since the last clear, stopping at saturation.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_tick && !o_sat) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/ir_frame_ctrl.sv
// NEC IR frame decoder: measures mark/space phases in ticks and checks them
// against the windows in ir_pkg.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | line idle, waiting for a falling edge
// LEAD_MARK  | timing the 9 ms leader mark
// LEAD_SPACE | timing leader space: 4.5 ms frame or 2.25 ms repeat
// BIT_MARK   | timing the 562 us mark preceding each data bit
// BIT_SPACE  | timing the data space: short = 0, long = 1
// STOP_MARK  | timing the final mark; its rising edge completes the frame
module ir_frame_ctrl
  import ir_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick,
  input  logic       i_ir_n,
  output logic [7:0] o_addr,
  output logic [7:0] o_cmd,
  output logic       o_valid,
  output logic       o_repeat,
  output logic       o_error,
  output logic       o_busy
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ir_prev;
  logic                   ir_s;
  logic                   ir_edge;
  logic                   ir_fall;
  logic [TCOUNT_W-1:0]    cnt;
  logic                   cnt_sat;
  logic                   phase_ok;
  state_t                 state;
  logic [31:0]            shreg;
  logic [4:0]             bit_idx;
  logic                   is_rep;
  logic                   seen;

  assign ir_s    = sync_q[SYNC_STAGES-1];
  assign ir_edge = ir_s ^ ir_prev;
  assign ir_fall = ir_edge & ~ir_s;
  assign o_busy  = (state != IDLE);

  // Bring the asynchronous pin into the clock domain; idle line is space (1).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q  <= '1;
      ir_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_ir_n};
      ir_prev <= ir_s;
    end
  end

  // Each edge restarts phase timing; a coincident tick is dropped by the clear.
  pulse_timer u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (ir_edge),
    .i_tick    (i_tick),
    .o_count   (cnt),
    .o_sat     (cnt_sat)
  );

  // Is the phase that is ending now inside its window?
  always_comb begin
    phase_ok = 1'b0;
    unique case (state)
      LEAD_MARK:  phase_ok = in_window(cnt, LEAD_MARK_MIN, LEAD_MARK_MAX);
      LEAD_SPACE: phase_ok = in_window(cnt, FRAME_SPACE_MIN, FRAME_SPACE_MAX) ||
                             in_window(cnt, REP_SPACE_MIN, REP_SPACE_MAX);
      BIT_MARK:   phase_ok = in_window(cnt, BIT_MARK_MIN, BIT_MARK_MAX);
      BIT_SPACE:  phase_ok = in_window(cnt, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                             in_window(cnt, ONE_SPACE_MIN, ONE_SPACE_MAX);
      STOP_MARK:  phase_ok = in_window(cnt, STOP_MARK_MIN, STOP_MARK_MAX);
      default:    phase_ok = 1'b0;
    endcase
  end

  // Frame sequencing, bit assembly and registered result pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      is_rep   <= 1'b0;
      seen     <= 1'b0;
      o_addr   <= '0;
      o_cmd    <= '0;
      o_valid  <= 1'b0;
      o_repeat <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      o_valid  <= 1'b0;
      o_repeat <= 1'b0;
      o_error  <= 1'b0;
      if (state == IDLE) begin
        if (ir_fall) state <= LEAD_MARK;
      end else if (cnt_sat || (ir_edge && !phase_ok)) begin
        o_error <= 1'b1;
        state   <= IDLE;
      end else if (ir_edge) begin
        unique case (state)
          LEAD_MARK: state <= LEAD_SPACE;
          LEAD_SPACE: begin
            if (in_window(cnt, FRAME_SPACE_MIN, FRAME_SPACE_MAX)) begin
              state   <= BIT_MARK;
              bit_idx <= '0;
              is_rep  <= 1'b0;
            end else begin
              state  <= STOP_MARK;
              is_rep <= 1'b1;
            end
          end
          BIT_MARK: state <= BIT_SPACE;
          BIT_SPACE: begin
            shreg <= {in_window(cnt, ONE_SPACE_MIN, ONE_SPACE_MAX), shreg[31:1]};
            if (bit_idx == 5'd31) begin
              state <= STOP_MARK;
            end else begin
              state   <= BIT_MARK;
              bit_idx <= bit_idx + 5'd1;
            end
          end
          STOP_MARK: begin
            state <= IDLE;
            if (is_rep) begin
              o_repeat <= seen;
              o_error  <= ~seen;
            end else if ((shreg[7:0] == ~shreg[15:8]) &&
                         (shreg[23:16] == ~shreg[31:24])) begin
              o_valid <= 1'b1;
              o_addr  <= shreg[7:0];
              o_cmd   <= shreg[23:16];
              seen    <= 1'b1;
            end else begin
              o_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_frame_ctrl.sv
// Directed bench for ir_frame_ctrl: NEC frames, repeats and window edges.
module tb_ir_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       ir_n = 1'b1;
  logic [7:0] o_addr, o_cmd;
  logic       o_valid, o_repeat, o_error, o_busy;

  int checks = 0;
  int errors = 0;
  int v_cnt = 0, r_cnt = 0, e_cnt = 0, multi = 0;

  ir_frame_ctrl #(.SYNC_STAGES(2)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_tick    (tick),
    .i_ir_n    (ir_n),
    .o_addr    (o_addr),
    .o_cmd     (o_cmd),
    .o_valid   (o_valid),
    .o_repeat  (o_repeat),
    .o_error   (o_error),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  // Tally result pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid)  v_cnt++;
      if (o_repeat) r_cnt++;
      if (o_error)  e_cnt++;
      if ((int'(o_valid) + int'(o_repeat) + int'(o_error)) > 1) multi++;
    end
  end

  task automatic clear_cnts();
    v_cnt = 0; r_cnt = 0; e_cnt = 0;
  endtask

  task automatic level(input logic lvl);
    @(negedge clk) ir_n = lvl;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  // Change the line, let the synchronizer settle, then let n ticks elapse.
  task automatic phase(input logic lvl, input int n);
    level(lvl);
    repeat (3) @(negedge clk);
    ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c,
                            input logic [7:0] ci, input int lead,
                            input bit coinc, input int nbits);
    logic [31:0] w;
    w = {ci, c, ~a, a};
    phase(1'b0, lead);
    phase(1'b1, 80);
    for (int i = 0; i < nbits; i++) begin
      if (coinc && i == 0) begin
        phase(1'b0, 13);
        // rising edge is seen by the FSM in the same cycle as a tick
        level(1'b1);
        @(negedge clk);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        ticks(w[i] ? 30 : 10);
      end else begin
        phase(1'b0, 10);
        phase(1'b1, w[i] ? 30 : 10);
      end
    end
    if (nbits == 32) begin
      phase(1'b0, 10);
      level(1'b1);
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic send_repeat();
    phase(1'b0, 160);
    phase(1'b1, 40);
    phase(1'b0, 10);
    level(1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (o_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", o_addr); end
    checks++; if (o_cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h want 00", o_cmd); end
    checks++; if ({o_valid, o_repeat, o_error, o_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {o_valid, o_repeat, o_error, o_busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", o_busy); end
  endtask

  task automatic test_repeat_no_frame();
    clear_cnts();
    send_repeat();
    checks++; if (e_cnt !== 1 || r_cnt !== 0) begin
      errors++; $display("FAIL rep_no_frame err %0d rep %0d want 1 0", e_cnt, r_cnt);
    end
  endtask

  task automatic test_frame();
    clear_cnts();
    send_frame(8'h12, 8'h5A, 8'hA5, 160, 1'b0, 32);
    checks++; if (v_cnt !== 1 || e_cnt !== 0) begin
      errors++; $display("FAIL frame_pulses valid %0d err %0d want 1 0", v_cnt, e_cnt);
    end
    checks++; if (o_addr !== 8'h12) begin errors++; $display("FAIL frame_addr got %h want 12", o_addr); end
    checks++; if (o_cmd !== 8'h5A) begin errors++; $display("FAIL frame_cmd got %h want 5a", o_cmd); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL frame_busy got %b want 0", o_busy); end
  endtask

  task automatic test_repeat();
    clear_cnts();
    send_repeat();
    checks++; if (r_cnt !== 1 || e_cnt !== 0 || v_cnt !== 0) begin
      errors++; $display("FAIL repeat_pulses rep %0d err %0d valid %0d want 1 0 0", r_cnt, e_cnt, v_cnt);
    end
    checks++; if (o_addr !== 8'h12 || o_cmd !== 8'h5A) begin
      errors++; $display("FAIL repeat_hold got %h/%h want 12/5a", o_addr, o_cmd);
    end
  endtask

  task automatic test_bad_check();
    clear_cnts();
    send_frame(8'h12, 8'h5A, 8'hA4, 160, 1'b0, 32);
    checks++; if (e_cnt !== 1 || v_cnt !== 0) begin
      errors++; $display("FAIL badchk_pulses err %0d valid %0d want 1 0", e_cnt, v_cnt);
    end
    checks++; if (o_addr !== 8'h12 || o_cmd !== 8'h5A) begin
      errors++; $display("FAIL badchk_hold got %h/%h want 12/5a", o_addr, o_cmd);
    end
  endtask

  task automatic test_lead_window();
    clear_cnts();
    phase(1'b0, 100);
    level(1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++; if (o_error !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL lead100_early err %b busy %b want 0 1", o_error, o_busy);
    end
    @(negedge clk);
    checks++; if (o_error !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL lead100_pulse err %b busy %b want 1 0", o_error, o_busy);
    end
    repeat (4) @(negedge clk);
    clear_cnts();
    send_frame(8'h34, 8'h01, 8'hFE, 176, 1'b0, 32);
    checks++; if (v_cnt !== 1 || e_cnt !== 0 || o_addr !== 8'h34 || o_cmd !== 8'h01) begin
      errors++; $display("FAIL lead176 valid %0d err %0d addr %h cmd %h want 1 0 34 01", v_cnt, e_cnt, o_addr, o_cmd);
    end
    clear_cnts();
    send_frame(8'h55, 8'h66, 8'h99, 177, 1'b0, 0);
    checks++; if (e_cnt !== 1 || o_busy !== 1'b0 || o_addr !== 8'h34) begin
      errors++; $display("FAIL lead177 err %0d busy %b addr %h want 1 0 34", e_cnt, o_busy, o_addr);
    end
  endtask

  task automatic test_coincident();
    clear_cnts();
    send_frame(8'hA5, 8'h3C, 8'hC3, 160, 1'b1, 32);
    checks++; if (v_cnt !== 1 || e_cnt !== 0 || o_addr !== 8'hA5 || o_cmd !== 8'h3C) begin
      errors++; $display("FAIL coinc13 valid %0d err %0d addr %h cmd %h want 1 0 a5 3c", v_cnt, e_cnt, o_addr, o_cmd);
    end
  endtask

  task automatic test_saturation();
    clear_cnts();
    send_frame(8'h12, 8'h5A, 8'hA5, 160, 1'b0, 5);
    phase(1'b0, 254);
    checks++; if (e_cnt !== 0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL sat_254 err %0d busy %b want 0 1", e_cnt, o_busy);
    end
    ticks(1);
    repeat (2) @(negedge clk);
    checks++; if (e_cnt !== 1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL sat_255 err %0d busy %b want 1 0", e_cnt, o_busy);
    end
    ticks(45);
    level(1'b1);
    repeat (6) @(negedge clk);
    checks++; if (e_cnt !== 1 || o_busy !== 1'b0 || o_addr !== 8'hA5) begin
      errors++; $display("FAIL sat_release err %0d busy %b addr %h want 1 0 a5", e_cnt, o_busy, o_addr);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_cnts();
    send_frame(8'h77, 8'h88, 8'h77, 160, 1'b0, 17);
    phase(1'b0, 5);
    checks++; if (o_busy !== 1'b1 || o_addr !== 8'hA5) begin
      errors++; $display("FAIL pre_reset busy %b addr %h want 1 a5", o_busy, o_addr);
    end
    #3;
    rst_n = 1'b0;
    ir_n  = 1'b1;
    #1;
    checks++; if ({o_addr, o_cmd} !== 16'h0000 || {o_valid, o_repeat, o_error, o_busy} !== 4'b0000) begin
      errors++; $display("FAIL async_reset addr %h cmd %h flags %b want 00 00 0000",
                         o_addr, o_cmd, {o_valid, o_repeat, o_error, o_busy});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_cnts();
    send_repeat();
    checks++; if (e_cnt !== 1 || r_cnt !== 0) begin
      errors++; $display("FAIL rep_after_reset err %0d rep %0d want 1 0", e_cnt, r_cnt);
    end
    clear_cnts();
    send_frame(8'hC7, 8'h38, 8'hC7, 160, 1'b0, 32);
    checks++; if (v_cnt !== 1 || e_cnt !== 0 || o_addr !== 8'hC7 || o_cmd !== 8'h38) begin
      errors++; $display("FAIL post_reset_frame valid %0d err %0d addr %h cmd %h want 1 0 c7 38",
                         v_cnt, e_cnt, o_addr, o_cmd);
    end
  endtask

  task automatic test_exclusive();
    checks++; if (multi !== 0) begin
      errors++; $display("FAIL exclusive_pulses got %0d overlapping cycles want 0", multi);
    end
  endtask

  initial begin
    test_reset();
    test_repeat_no_frame();
    test_frame();
    test_repeat();
    test_bad_check();
    test_lead_window();
    test_coincident();
    test_saturation();
    test_reset_mid_frame();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
